// File: rtl/freq_gate_counter.sv
// Gated frequency meter: counts synchronised rising edges of sig_in over GATE_CYCLES clk cycles.
// Optional sticky overflow flag (port cnt_ovf) is built when FREQ_CNT_OVF_EN is defined.
module freq_gate_counter #(
  parameter int GATE_CYCLES = 50000,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             cnt_valid,
  output logic             busy
`ifdef FREQ_CNT_OVF_EN
  ,
  output logic             cnt_ovf
`endif
);

  localparam int                TIMER_W    = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;

  typedef enum logic [1:0] {IDLE, ARM, GATE, LATCH} state_t;

  state_t             state;
  logic [SYNC_STAGES-1:0] sync;
  logic               sync_d;
  logic               edge_det;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   counter_next;
  logic               at_max;
  logic               last_cycle;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      sync_d <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], sig_in};
      sync_d <= sync[SYNC_STAGES-1];
    end
  end

  assign edge_det   = sync[SYNC_STAGES-1] & ~sync_d;
  assign at_max     = (counter == CNT_MAX);
  assign last_cycle = (timer == TIMER_LAST);

  // NOTE: default first, so every path through the block assigns counter_next and no latch forms.
  always_comb begin
    counter_next = counter;
    if (state == GATE && edge_det && !at_max)
      counter_next = counter + 1'b1;
  end

  // The result is loaded on the edge that enters LATCH, so freq_cnt and cnt_valid
  // are both presented during the LATCH cycle, including an edge seen on the last GATE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      timer     <= '0;
      counter   <= '0;
      freq_cnt  <= '0;
      cnt_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end
        ARM: begin
          counter <= '0;
          timer   <= '0;
          state   <= GATE;
        end
        GATE: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            counter <= counter_next;
            timer   <= timer + 1'b1;
            if (last_cycle) begin
              freq_cnt  <= counter_next;
              cnt_valid <= 1'b1;
              state     <= LATCH;
            end
          end
        end
        LATCH: begin
          if (enable) begin
            state <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_CNT_OVF_EN
  logic ovf_win;
  logic ovf_now;

  assign ovf_now = (state == GATE) && enable && edge_det && at_max;

  // The flag is re-evaluated at each latch from this window's history alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_win <= 1'b0;
      cnt_ovf <= 1'b0;
    end else if (state == ARM) begin
      ovf_win <= 1'b0;
    end else if (state == GATE && enable) begin
      if (ovf_now) begin
        ovf_win <= 1'b1;
        cnt_ovf <= 1'b1;
      end
      if (last_cycle)
        cnt_ovf <= ovf_win | ovf_now;
    end
  end
`endif

endmodule

// File: tb/tb_freq_gate_counter.sv
// Self-checking bench for freq_gate_counter: scoreboard of expected window results,
// a 16-bit instance for the main behaviour and a 4-bit instance for saturation.
module tb_freq_gate_counter;

  localparam int GC = 100;

  typedef struct {
    int cnt;
    bit ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        enable4;
  logic        sig_in;
  logic [15:0] freq_cnt;
  logic        cnt_valid;
  logic        busy;
  logic [3:0]  freq_cnt4;
  logic        cnt_valid4;
  logic        busy4;
`ifdef FREQ_CNT_OVF_EN
  logic        cnt_ovf;
  logic        cnt_ovf4;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   gen_period = 0;   // >0 periodic, 0 held low, <0 copy man_sig
  logic man_sig = 1'b0;
  int   exp_q[$];
  exp_t exp4_q[$];

  freq_gate_counter #(.GATE_CYCLES(GC), .CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sig_in(sig_in),
    .freq_cnt(freq_cnt), .cnt_valid(cnt_valid), .busy(busy)
`ifdef FREQ_CNT_OVF_EN
    , .cnt_ovf(cnt_ovf)
`endif
  );

  freq_gate_counter #(.GATE_CYCLES(GC), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable4), .sig_in(sig_in),
    .freq_cnt(freq_cnt4), .cnt_valid(cnt_valid4), .busy(busy4)
`ifdef FREQ_CNT_OVF_EN
    , .cnt_ovf(cnt_ovf4)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_period < 0) begin
        sig_in = man_sig;
      end else if (gen_period == 0) begin
        sig_in = 1'b0;
        ph     = 0;
      end else begin
        ph     = (ph + 1 >= gen_period) ? 0 : ph + 1;
        sig_in = (ph < gen_period / 2);
      end
    end
  end

  task automatic wait_valid(output int at_cyc);
    int n;
    int e;
    n      = 0;
    at_cyc = -1;
    @(negedge clk);
    while (!cnt_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL valid_timeout: cnt_valid=%b after %0d cycles, required 1", cnt_valid, n);
    end else begin
      at_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: freq_cnt=%0d, no result expected", freq_cnt);
      end else begin
        e = exp_q.pop_front();
        if (freq_cnt !== 16'(e)) begin
          errors++;
          $display("FAIL freq_cnt: got %0d, required %0d", freq_cnt, e);
        end
      end
    end
  endtask

  task automatic wait_valid4();
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!cnt_valid4 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cnt_valid4 !== 1'b1) begin
      errors++;
      $display("FAIL valid4_timeout: cnt_valid=%b after %0d cycles, required 1", cnt_valid4, n);
    end else if (exp4_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_valid4: freq_cnt=%0d, no result expected", freq_cnt4);
    end else begin
      e = exp4_q.pop_front();
      checks++;
      if (freq_cnt4 !== 4'(e.cnt)) begin
        errors++;
        $display("FAIL freq_cnt4: got %0d, required %0d", freq_cnt4, e.cnt);
      end
`ifdef FREQ_CNT_OVF_EN
      checks++;
      if (cnt_ovf4 !== e.ovf) begin
        errors++;
        $display("FAIL cnt_ovf4_latch: got %b, required %b", cnt_ovf4, e.ovf);
      end
`endif
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    enable4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (freq_cnt !== 16'd0) begin errors++; $display("FAIL reset_freq_cnt: got %0d, required 0", freq_cnt); end
    checks++;
    if (cnt_valid !== 1'b0) begin errors++; $display("FAIL reset_cnt_valid: got %b, required 0", cnt_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
`ifdef FREQ_CNT_OVF_EN
    checks++;
    if (cnt_ovf !== 1'b0) begin errors++; $display("FAIL reset_cnt_ovf: got %b, required 0", cnt_ovf); end
`endif
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b, required 0", busy); end
  endtask

  task automatic test_period10();
    int c0, c1, c2;
    gen_period = 10;
    repeat (30) @(negedge clk);
    repeat (3) exp_q.push_back(10);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_active: got %b, required 1", busy); end
    wait_valid(c0);
    wait_valid(c1);
    wait_valid(c2);
    enable = 1'b0;
    checks++;
    if (c1 - c0 !== 102) begin errors++; $display("FAIL valid_spacing_1: got %0d, required 102", c1 - c0); end
    checks++;
    if (c2 - c1 !== 102) begin errors++; $display("FAIL valid_spacing_2: got %0d, required 102", c2 - c1); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop: got %b, required 0", busy); end
    checks++;
    if (freq_cnt !== 16'd10) begin errors++; $display("FAIL freq_cnt_hold: got %0d, required 10", freq_cnt); end
  endtask

  task automatic test_abort();
    int n_valid;
    n_valid = 0;
    @(negedge clk);
    enable = 1'b1;
    repeat (52) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b, required 1", busy); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b, required 0", busy); end
    checks++;
    if (freq_cnt !== 16'd10) begin errors++; $display("FAIL abort_freq_cnt: got %0d, required 10", freq_cnt); end
    repeat (150) begin
      @(negedge clk);
      if (cnt_valid) n_valid++;
    end
    checks++;
    if (n_valid !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses, required 0", n_valid); end
  endtask

  // Pulses rise after posedge E(m) and are counted at E(m+3); E0 moves IDLE to ARM.
  task automatic manual_window(input int first, input int n, input int extra);
    int hi;
    bit pulse;
    int e_cnt;
    hi = 0;
    @(negedge clk);
    enable = 1'b1;
    for (int e = 0; e <= 105; e++) begin
      @(posedge clk);
      #1;
      pulse = (e == extra) || (e >= first && (e - first) % 9 == 0 && (e - first) / 9 < n);
      if (pulse) hi = 3;
      man_sig = (hi > 0);
      if (hi > 0) hi--;
      if (e == 101) begin
        enable = 1'b0;
        checks++;
        if (cnt_valid !== 1'b1) begin
          errors++;
          $display("FAIL edge_window_valid: got %b, required 1", cnt_valid);
        end else begin
          e_cnt = exp_q.pop_front();
          checks++;
          if (freq_cnt !== 16'(e_cnt)) begin
            errors++;
            $display("FAIL edge_window_cnt: got %0d, required %0d", freq_cnt, e_cnt);
          end
        end
      end
    end
  endtask

  task automatic test_last_edge();
    gen_period = -1;
    man_sig    = 1'b0;
    repeat (10) @(negedge clk);
    exp_q.push_back(11);
    manual_window(8, 11, -1);
    repeat (10) @(negedge clk);
    exp_q.push_back(10);
    manual_window(9, 10, 99);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_silent();
    int c;
    gen_period = 0;
    repeat (10) @(negedge clk);
    exp_q.push_back(0);
    enable = 1'b1;
    wait_valid(c);
    enable = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_overflow();
    exp_t t;
    gen_period = 2;
    repeat (10) @(negedge clk);
    t.cnt = 15;
    t.ovf = 1'b1;
    exp4_q.push_back(t);
    enable4 = 1'b1;
    wait_valid4();
    enable4 = 1'b0;
    gen_period = 10;
    repeat (30) @(negedge clk);
`ifdef FREQ_CNT_OVF_EN
    checks++;
    if (cnt_ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky_idle: got %b, required 1", cnt_ovf4); end
`endif
    t.cnt = 10;
    t.ovf = 1'b0;
    exp4_q.push_back(t);
    enable4 = 1'b1;
    repeat (20) @(negedge clk);
`ifdef FREQ_CNT_OVF_EN
    checks++;
    if (cnt_ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky_gate: got %b, required 1", cnt_ovf4); end
`endif
    wait_valid4();
    enable4 = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid_window();
    int c;
    exp_q.push_back(10);
    enable = 1'b1;
    wait_valid(c);
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b, required 1", busy); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (freq_cnt !== 16'd0) begin errors++; $display("FAIL mid_reset_freq_cnt: got %0d, required 0", freq_cnt); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    checks++;
    if (cnt_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b, required 0", cnt_valid); end
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (freq_cnt4 !== 4'd0) begin errors++; $display("FAIL mid_reset_freq_cnt4: got %0d, required 0", freq_cnt4); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b, required 0", busy); end
  endtask

  initial begin
    test_reset();
    test_period10();
    test_abort();
    test_last_edge();
    test_silent();
    test_overflow();
    test_reset_mid_window();
    checks++;
    if (exp_q.size() + exp4_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drained: %0d results still pending, required 0", exp_q.size() + exp4_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
